// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths and writeback request type for the writeback arbiter
package regfile_wb_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-write vector for in-flight mul/div destinations and issue hazard stall
// Ports: clk, rst_n (async active-low); issue_*_i describe the issuing instruction;
// clr_valid_i/clr_addr_i mark an MD writeback transfer; issue_stall_o is the combinational hazard stall.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid_i,
  input  logic                  issue_md_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic [REG_ADDR_W-1:0] issue_rs1_i,
  input  logic [REG_ADDR_W-1:0] issue_rs2_i,
  input  logic                  clr_valid_i,
  input  logic [REG_ADDR_W-1:0] clr_addr_i,
  output logic                  issue_stall_o
);
  logic [NUM_REGS-1:1] pending_q, pending_d;
  logic [NUM_REGS-1:0] live;
  logic                fire;
  // x0 is never tracked, so it reads as not pending
  assign live = {pending_q, 1'b0};
  assign issue_stall_o = issue_valid_i & (live[issue_rs1_i] | live[issue_rs2_i] | live[issue_rd_i]);
  assign fire = issue_valid_i & issue_md_i & ~issue_stall_o & (issue_rd_i != '0);
  // set has priority over a same-cycle clear of the same register
  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < NUM_REGS; i++)
      pending_d[i] = (fire && issue_rd_i == REG_ADDR_W'(i)) ||
                     (pending_q[i] && !(clr_valid_i && clr_addr_i == REG_ADDR_W'(i)));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU and mul/div writebacks onto one register file write port
// Ports: clk, rst_n (async active-low); alu_valid/addr/data + alu_ready and md_valid/addr/data + md_ready
// are valid/ready writeback requests; rf_we/rf_waddr/rf_wdata is the registered write port (latency 1);
// issue_* describe the issuing instruction and issue_stall is the hazard stall.
// Optional feature: define WB_SCOREBOARD_EN to add the pending-write scoreboard; otherwise issue_stall is 0.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_addr,
  input  logic [XLEN-1:0]       md_data,
  output logic                  md_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  input  logic                  issue_valid,
  input  logic                  issue_md,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  output logic                  issue_stall
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0]            starve_q, starve_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
  logic                  forced, alu_fire, md_fire;
  wb_req_t               win;
  // MD wins unconditionally once it has lost STARVE_LIMIT arbitrations in a row
  assign forced = md_valid & (starve_q == LIMIT);
  assign alu_ready = rst_n & alu_valid & ~forced;
  assign md_ready = rst_n & md_valid & (~alu_valid | forced);
  assign alu_fire = alu_valid & alu_ready;
  assign md_fire = md_valid & md_ready;
  // writes to x0 are accepted but never reach the register file, and the port holds its last value
  always_comb begin
    win.valid = alu_fire | md_fire;
    win.addr = alu_fire ? alu_addr : md_addr;
    win.data = alu_fire ? alu_data : md_data;
    rf_we_d = win.valid & (win.addr != '0);
    rf_waddr_d = rf_we_d ? win.addr : rf_waddr_q;
    rf_wdata_d = rf_we_d ? win.data : rf_wdata_q;
    starve_d = md_fire ? '0 : (md_valid && starve_q != LIMIT) ? starve_q + 4'd1 : starve_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      starve_q <= '0;
      rf_we_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      starve_q <= starve_d;
      rf_we_q <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  assign rf_we = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
`ifdef WB_SCOREBOARD_EN
  wb_scoreboard u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid_i(issue_valid),
    .issue_md_i   (issue_md),
    .issue_rd_i   (issue_rd),
    .issue_rs1_i  (issue_rs1),
    .issue_rs2_i  (issue_rs2),
    .clr_valid_i  (md_fire),
    .clr_addr_i   (md_addr),
    .issue_stall_o(issue_stall)
  );
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid, issue_md, issue_rd, issue_rs1, issue_rs2};
  assign issue_stall = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: self-checking bench with a behavioural model and directed vectors
module tb_regfile_wb_arbiter;
  localparam int SL = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic alu_valid, md_valid, alu_ready, md_ready, rf_we;
  logic [4:0] alu_addr, md_addr, rf_waddr;
  logic [31:0] alu_data, md_data, rf_wdata;
  logic issue_valid, issue_md, issue_stall;
  logic [4:0] issue_rd, issue_rs1, issue_rs2;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  regfile_wb_arbiter #(.STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .issue_valid(issue_valid), .issue_md(issue_md), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_stall(issue_stall)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  // behavioural model: count of consecutive MD losses, the expected write port, pending registers
  int lost;
  logic m_we;
  logic [4:0] m_addr;
  logic [31:0] m_data;
  logic [31:0] pend;
  logic e_forced, e_ar, e_mr, e_stall, e_issue;
  assign e_forced = md_valid && lost == SL;
  assign e_ar = rst_n && alu_valid && !e_forced;
  assign e_mr = rst_n && md_valid && (!alu_valid || e_forced);
`ifdef WB_SCOREBOARD_EN
  assign e_stall = rst_n && issue_valid && ((issue_rs1 != 0 && pend[issue_rs1]) ||
                   (issue_rs2 != 0 && pend[issue_rs2]) || (issue_rd != 0 && pend[issue_rd]));
`else
  assign e_stall = 1'b0;
`endif
  assign e_issue = issue_valid && issue_md && !e_stall && issue_rd != 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost <= 0; m_we <= 0; m_addr <= 0; m_data <= 0; pend <= 0;
    end else begin
      m_we <= (e_ar && alu_addr != 0) || (e_mr && md_addr != 0);
      if (e_ar && alu_addr != 0) begin m_addr <= alu_addr; m_data <= alu_data; end
      else if (e_mr && md_addr != 0) begin m_addr <= md_addr; m_data <= md_data; end
      lost <= e_mr ? 0 : md_valid ? ((lost + 1 > SL) ? SL : lost + 1) : lost;
`ifdef WB_SCOREBOARD_EN
      for (int i = 1; i < 32; i++)
        if (e_issue && issue_rd == 5'(i)) pend[i] <= 1'b1;
        else if (e_mr && md_addr == 5'(i)) pend[i] <= 1'b0;
`endif
    end
  end
  always @(negedge clk) begin
    chk("alu_ready", alu_ready, e_ar);
    chk("md_ready", md_ready, e_mr);
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_addr);
    chk("rf_wdata", rf_wdata, m_data);
    chk("issue_stall", issue_stall, e_stall);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    md_valid = 0; md_addr = 0; md_data = 0;
    issue_valid = 0; issue_md = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
  endtask
  // directed table: {alu_valid, alu_addr, md_valid, md_addr, rf_we expected next cycle}
  typedef struct { bit av; logic [4:0] aa; bit mv; logic [4:0] ma; bit we; } vec_t;
  vec_t tab [10] = '{
    '{1, 3, 0, 0, 1}, '{1, 4, 0, 0, 1}, '{0, 0, 1, 6, 1}, '{1, 8, 1, 10, 1}, '{1, 0, 1, 10, 0},
    '{0, 0, 0, 0, 0}, '{1, 13, 1, 14, 1}, '{1, 15, 1, 14, 1}, '{1, 15, 1, 14, 1}, '{0, 0, 1, 0, 0}
  };
  initial begin
    idle();
    alu_valid = 1; alu_addr = 3; md_valid = 1; md_addr = 4; issue_valid = 1; issue_rs1 = 5;
    @(negedge clk);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_md_ready", md_ready, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_stall", issue_stall, 0);
    cyc();
    rst_n = 1;
    idle();
    alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_alu_ready", alu_ready, 1);
    chk("t1_md_ready", md_ready, 0);
    cyc();
    idle();
    chk("t1_rf_we", rf_we, 1);
    chk("t1_rf_waddr", rf_waddr, 5);
    chk("t1_rf_wdata", rf_wdata, 32'hDEADBEEF);
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1; alu_addr = 1; alu_data = i;
      md_valid = 1; md_addr = 2; md_data = 100 + i;
      @(negedge clk);
      chk("starve_alu_ready", alu_ready, i != 4);
      chk("starve_md_ready", md_ready, i == 4);
      cyc();
      if (i == 4) begin
        chk("starve_md_waddr", rf_waddr, 2);
        chk("starve_md_wdata", rf_wdata, 104);
      end
    end
    idle();
    alu_valid = 1; alu_addr = 0; alu_data = 32'h1234;
    @(negedge clk);
    chk("x0_alu_ready", alu_ready, 1);
    cyc();
    idle();
    chk("x0_rf_we", rf_we, 0);
    chk("x0_hold_waddr", rf_waddr, 1);
    chk("x0_hold_wdata", rf_wdata, 5);
    foreach (tab[k]) begin
      alu_valid = tab[k].av; alu_addr = tab[k].aa; alu_data = 32'h1000 + k;
      md_valid = tab[k].mv; md_addr = tab[k].ma; md_data = 32'h2000 + k;
      cyc();
      chk("tab_rf_we", rf_we, tab[k].we);
    end
    idle();
    cyc();
`ifdef WB_SCOREBOARD_EN
    issue_valid = 1; issue_md = 1; issue_rd = 7;
    @(negedge clk);
    chk("sb_issue7_stall", issue_stall, 0);
    cyc();
    issue_md = 0; issue_rd = 0; issue_rs1 = 7;
    @(negedge clk);
    chk("sb_rs1_stall", issue_stall, 1);
    cyc();
    @(negedge clk);
    chk("sb_rs1_stall_hold", issue_stall, 1);
    cyc();
    md_valid = 1; md_addr = 7; md_data = 32'h77;
    @(negedge clk);
    chk("sb_clr_md_ready", md_ready, 1);
    chk("sb_clr_stall", issue_stall, 1);
    cyc();
    md_valid = 0;
    chk("sb_rel_rf_we", rf_we, 1);
    chk("sb_rel_waddr", rf_waddr, 7);
    @(negedge clk);
    chk("sb_rel_stall", issue_stall, 0);
    cyc();
    issue_valid = 1; issue_md = 1; issue_rd = 9; issue_rs1 = 0;
    md_valid = 1; md_addr = 9; md_data = 32'h99;
    @(negedge clk);
    chk("sb_same_stall", issue_stall, 0);
    chk("sb_same_md_ready", md_ready, 1);
    cyc();
    md_valid = 0; issue_md = 0; issue_rd = 0; issue_rs1 = 9;
    @(negedge clk);
    chk("sb_setwins_stall", issue_stall, 1);
    cyc();
    md_valid = 1; md_addr = 9;
    cyc();
    md_valid = 0;
    @(negedge clk);
    chk("sb_clr9_stall", issue_stall, 0);
`else
    issue_valid = 1; issue_md = 1; issue_rd = 7; issue_rs1 = 7;
    @(negedge clk);
    chk("nosb_stall", issue_stall, 0);
    cyc();
    @(negedge clk);
    chk("nosb_stall_again", issue_stall, 0);
`endif
    cyc();
    idle();
    alu_valid = 1; alu_addr = 11; alu_data = 32'hAA;
    @(negedge clk);
    chk("rst_xfer_alu_ready", alu_ready, 1);
    cyc();
    chk("rst_xfer_rf_we", rf_we, 1);
    md_valid = 1; md_addr = 12;
    rst_n = 0;
    #1;
    chk("async_rf_we", rf_we, 0);
    chk("async_rf_waddr", rf_waddr, 0);
    chk("async_rf_wdata", rf_wdata, 0);
    chk("async_alu_ready", alu_ready, 0);
    cyc();
    cyc();
    rst_n = 1;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_rf_we", rf_we, 0);
    end
    cyc();
    alu_valid = 1; alu_addr = 20; alu_data = 32'h77;
    cyc();
    idle();
    chk("post_rst_xfer_we", rf_we, 1);
    chk("post_rst_xfer_waddr", rf_waddr, 20);
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, giving the number of consecutive lost MD arbitration cycles before MD is forced to win (legal range 1..15).
REQ-002 The block SHALL have ports `clk` (in, 1, the single clock) and `rst_n` (in, 1, asynchronous active-low reset).
REQ-003 The block SHALL have ports `alu_valid` (in, 1), `alu_addr` (in, 5) and `alu_data` (in, 32), forming the ALU writeback request.
REQ-004 The block SHALL have port `alu_ready` (out, 1), the ALU request accept.
REQ-005 The block SHALL have ports `md_valid` (in, 1), `md_addr` (in, 5) and `md_data` (in, 32), forming the mul/div writeback request.
REQ-006 The block SHALL have port `md_ready` (out, 1), the MD request accept.
REQ-007 The block SHALL have ports `rf_we` (out, 1), `rf_waddr` (out, 5) and `rf_wdata` (out, 32), which drive the register file write port.
REQ-008 The block SHALL have ports `issue_valid` (in, 1), `issue_md` (in, 1), `issue_rd` (in, 5), `issue_rs1` (in, 5) and `issue_rs2` (in, 5), describing the instruction at the issue stage.
REQ-009 The block SHALL have port `issue_stall` (out, 1), the hazard stall to issue.

Function
REQ-010 A transfer SHALL occur on a requester in any cycle where its valid and ready are both 1.
REQ-011 alu_ready and md_ready SHALL be combinational from the current valids and starvation state, and at most one SHALL be 1 per cycle.
REQ-012 Normal priority SHALL be ALU over MD: alu_ready=1 whenever alu_valid=1, unless forced-MD applies.
REQ-013 md_ready SHALL be 1 when md_valid=1 and either alu_valid=0 or forced-MD applies.
REQ-014 A 4-bit starvation counter SHALL increment each cycle md_valid=1 and md_ready=0, SHALL clear on an MD transfer, and SHALL saturate at STARVE_LIMIT.
REQ-015 Forced-MD SHALL apply when the counter equals STARVE_LIMIT and md_valid=1; alu_ready SHALL then be 0.
REQ-016 A transfer in cycle N SHALL register the request into rf_waddr/rf_wdata with rf_we=1 during cycle N+1, giving a latency of exactly 1.
REQ-017 rf_we SHALL be 0 in any cycle following a cycle with no transfer.
REQ-018 A transfer with address 0 SHALL be accepted (ready asserted normally) but SHALL produce rf_we=0 in cycle N+1.
REQ-019 rf_waddr/rf_wdata SHALL hold their last values while rf_we=0.
REQ-020 Back-to-back transfers SHALL yield back-to-back rf_we cycles with no bubble.

Reset
REQ-021 While rst_n=0, the block SHALL force rf_we=0, rf_waddr=0, rf_wdata=0, starvation counter=0, and all scoreboard bits=0, asynchronously.
REQ-022 During reset, alu_ready/md_ready SHALL be 0.
REQ-023 During reset, issue_stall SHALL be 0.
REQ-024 A reset asserted mid-transfer SHALL discard the pending write, so that no rf_we pulse follows reset release.
REQ-025 State SHALL leave reset on the first clk rising edge after rst_n rises.

Configuration
REQ-026 Macro WB_SCOREBOARD_EN defined: the block SHALL keep a 32-bit pending vector.
REQ-027 Under WB_SCOREBOARD_EN, a bit SHALL be set on issue fire (issue_valid=1, issue_md=1, issue_stall=0, issue_rd!=0).
REQ-028 Under WB_SCOREBOARD_EN, a bit SHALL be cleared on an MD transfer to that address; on a same-cycle set and clear of one address, set SHALL win.
REQ-029 Under WB_SCOREBOARD_EN, issue_stall SHALL equal issue_valid AND (pending[rs1] OR pending[rs2] OR pending[rd]), with index 0 ignored.
REQ-030 Under WB_SCOREBOARD_EN, issue_stall SHALL be combinational.
REQ-031 Under WB_SCOREBOARD_EN, the stall SHALL release in the cycle after the clearing transfer, which coincides with rf_we; the register file's same-cycle write forwarding covers the read.
REQ-032 Macro WB_SCOREBOARD_EN undefined: the block SHALL have no pending vector, issue_stall SHALL be tied 0, and issue_* inputs SHALL be ignored.

Structure
REQ-033 A shared package SHALL hold REG_ADDR_W=5, XLEN=32, NUM_REGS=32 and a writeback request struct type {valid, addr, data}.
REQ-034 The scoreboard SHALL be one sub-module, wb_scoreboard, instantiated only under WB_SCOREBOARD_EN; arbitration and the output register SHALL remain in the top.

Verification
REQ-035 The bench SHALL drive alu_valid=1 addr=5 data=0xDEADBEEF with md idle -> alu_ready=1; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-036 The bench SHALL hold alu_valid and md_valid at 1 continuously with STARVE_LIMIT=4 -> ALU wins 4 cycles, cycle 5 md_ready=1 and alu_ready=0, then the counter is 0 and the ALU wins again.
REQ-037 The bench SHALL drive an ALU transfer to addr=0 with data=0x1234 -> alu_ready=1, rf_we stays 0 next cycle.
REQ-038 (WB_SCOREBOARD_EN) The bench SHALL issue MD with rd=7, then issue_rs1=7 -> issue_stall=1 until the MD transfer to addr 7; stall=0 the following cycle, with rf_we=1, rf_waddr=7.
REQ-039 (WB_SCOREBOARD_EN) The bench SHALL issue MD with rd=9 in the same cycle as an MD transfer to addr 9 -> pending[9] remains 1.
REQ-040 The bench SHALL pull rst_n low the cycle after an accepted transfer -> rf_we=0 immediately and no write after release.
